// File: rtl/tl_pkg.sv
// Shared TileLink-UL constants and state encoding for the line-transfer initiators.
package tl_pkg;

  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  localparam int BEAT_W     = 128;
  localparam int BEAT_BYTES = BEAT_W / 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_PUT      = 3'd1;
  localparam state_t ST_GET      = 3'd2;
  localparam state_t ST_WAIT_ACK = 3'd3;
  localparam state_t ST_RECV     = 3'd4;
  localparam state_t ST_RESP     = 3'd5;

endpackage

// File: rtl/tl_line_master.sv
// Moves one cache line over TileLink-UL: a single Get gathering N data beats,
// or N PutFullData beats closed by one AccessAck.
module tl_line_master
  import tl_pkg::*;
#(
  parameter int         LINE_BYTES = 64,
  parameter logic [2:0] SOURCE_ID  = 3'd0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [31:0]             req_addr,
  input  logic [8*LINE_BYTES-1:0] req_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [8*LINE_BYTES-1:0] rsp_data,
  output logic                    rsp_err,
  output logic [2:0]              a_opcode,
  output logic [2:0]              a_param,
  output logic [7:0]              a_size,
  output logic [2:0]              a_source,
  output logic [31:0]             a_address,
  output logic [15:0]             a_mask,
  output logic [127:0]            a_data,
  output logic                    a_corrupt,
  output logic                    a_valid,
  input  logic                    a_ready,
  input  logic [2:0]              d_opcode,
  input  logic [1:0]              d_param,
  input  logic [7:0]              d_size,
  input  logic [2:0]              d_source,
  input  logic [2:0]              d_sink,
  input  logic                    d_denied,
  input  logic [127:0]            d_data,
  input  logic                    d_corrupt,
  input  logic                    d_valid,
  output logic                    d_ready
);

  localparam int          N      = LINE_BYTES / BEAT_BYTES;
  localparam int          LINE_W = 8 * LINE_BYTES;
  localparam int          CW     = $clog2(N) + 1;
  localparam logic [7:0]  A_SIZE = 8'($clog2(LINE_BYTES));
  localparam logic [31:0] OFF_MASK = 32'(LINE_BYTES) - 32'd1;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] buf_q;
  logic              err_q;
  logic              last;

  // Routing/ownership fields of the D channel carry nothing this block needs.
  logic unused_d;
  assign unused_d = ^{d_param, d_size, d_source, d_sink};

  assign last = (cnt_q == CW'(N - 1));

  // NOTE: the line buffer is reset along with the control state because rsp_data
  // must read zero out of reset; it is a flat register, not a RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr & ~OFF_MASK;
            buf_q   <= req_data;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            state_q <= req_wr ? ST_PUT : ST_GET;
          end
        end
        ST_PUT: begin
          if (a_ready) begin
            cnt_q <= cnt_q + 1'b1;
            if (last) state_q <= ST_WAIT_ACK;
          end
        end
        ST_GET: begin
          if (a_ready) begin
            cnt_q   <= '0;
            state_q <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (d_valid) begin
            buf_q[BEAT_W*int'(cnt_q) +: BEAT_W] <= d_data;
            cnt_q <= cnt_q + 1'b1;
            err_q <= err_q | d_denied | d_corrupt | (d_opcode != ACCESS_ACK_DATA);
            if (last) state_q <= ST_RESP;
          end
        end
        ST_WAIT_ACK: begin
          if (d_valid) begin
            err_q   <= err_q | d_denied | d_corrupt | (d_opcode != ACCESS_ACK);
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred;
  // A fields read zero whenever no beat is offered.
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    d_ready   = (state_q == ST_RECV) || (state_q == ST_WAIT_ACK);
    a_valid   = 1'b0;
    a_opcode  = '0;
    a_param   = '0;
    a_size    = '0;
    a_source  = '0;
    a_address = '0;
    a_mask    = '0;
    a_data    = '0;
    a_corrupt = 1'b0;
    case (state_q)
      ST_PUT: begin
        a_valid   = 1'b1;
        a_opcode  = PUT_FULL;
        a_size    = A_SIZE;
        a_source  = SOURCE_ID;
        a_address = addr_q + (32'(cnt_q) << 4);
        a_mask    = 16'hFFFF;
        a_data    = buf_q[BEAT_W*int'(cnt_q) +: BEAT_W];
      end
      ST_GET: begin
        a_valid   = 1'b1;
        a_opcode  = GET;
        a_size    = A_SIZE;
        a_source  = SOURCE_ID;
        a_address = addr_q;
        a_mask    = 16'hFFFF;
      end
      default: ;
    endcase
  end

  assign rsp_data = buf_q;
  assign rsp_err  = err_q;

endmodule

// File: tb/tb_tl_line_master.sv
// Bench for tl_line_master: a 128-bit TileLink memory slave plus a response scoreboard.
module tb_tl_line_master;

  localparam int LINE_BYTES = 64;
  localparam int N          = 4;
  localparam int LW         = 512;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_ready, req_wr;
  logic [31:0]     req_addr;
  logic [LW-1:0]   req_data;
  logic            rsp_valid, rsp_ready;
  logic [LW-1:0]   rsp_data;
  logic            rsp_err;
  logic [2:0]      a_opcode, a_param, a_source;
  logic [7:0]      a_size;
  logic [31:0]     a_address;
  logic [15:0]     a_mask;
  logic [127:0]    a_data;
  logic            a_corrupt, a_valid, a_ready;
  logic [2:0]      d_opcode, d_source, d_sink;
  logic [1:0]      d_param;
  logic [7:0]      d_size;
  logic            d_denied, d_corrupt, d_valid, d_ready;
  logic [127:0]    d_data;

  tl_line_master #(.LINE_BYTES(LINE_BYTES), .SOURCE_ID(3'd0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
    .a_address(a_address), .a_mask(a_mask), .a_data(a_data), .a_corrupt(a_corrupt),
    .a_valid(a_valid), .a_ready(a_ready),
    .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size), .d_source(d_source),
    .d_sink(d_sink), .d_denied(d_denied), .d_data(d_data), .d_corrupt(d_corrupt),
    .d_valid(d_valid), .d_ready(d_ready)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Slave model state
  typedef struct { logic [2:0] op; logic [127:0] data; logic denied; } dbeat_t;
  typedef struct { logic [2:0] op; logic [7:0] size; logic [31:0] addr; logic [15:0] mask; logic [127:0] data; } abeat_t;
  typedef struct { logic [LW-1:0] data; logic chk_data; logic err; } exp_t;

  logic [127:0] mem [logic [27:0]];
  dbeat_t       d_q[$];
  abeat_t       a_log[$];
  int unsigned  put_cyc[$];
  exp_t         sb[$];
  int           put_beats  = 0;
  int           deny_beat  = -1;
  bit           rand_ready = 1'b0;
  int           d_cnt      = 0;
  int unsigned  last_d_cyc = 0;
  bit           prev_stall = 1'b0;
  logic [31:0]  prev_addr;
  logic [127:0] prev_data;

  initial begin
    a_ready = 1'b1; d_valid = 1'b0; d_opcode = '0; d_param = '0; d_size = '0;
    d_source = '0; d_sink = '0; d_denied = 1'b0; d_data = '0; d_corrupt = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        d_q.delete();
        d_valid    = 1'b0;
        put_beats  = 0;
        prev_stall = 1'b0;
      end else begin
        if (d_q.size() != 0) begin
          d_valid  = 1'b1;
          d_opcode = d_q[0].op;
          d_data   = d_q[0].data;
          d_denied = d_q[0].denied;
          if (d_ready) begin
            void'(d_q.pop_front());
            d_cnt++;
            last_d_cyc = cyc;
          end
        end else begin
          d_valid  = 1'b0;
          d_denied = 1'b0;
        end
        a_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (prev_stall && a_valid) begin
          check("stall_addr", LW'(a_address), LW'(prev_addr));
          check("stall_data", LW'(a_data), LW'(prev_data));
        end
        prev_stall = a_valid && !a_ready;
        prev_addr  = a_address;
        prev_data  = a_data;
        if (a_valid && a_ready) begin
          a_log.push_back('{a_opcode, a_size, a_address, a_mask, a_data});
          if (a_opcode == 3'd4) begin
            for (int k = 0; k < N; k++)
              d_q.push_back('{3'd1, mem[a_address[31:4] + 28'(k)], k == deny_beat});
          end else begin
            mem[a_address[31:4]] = a_data;
            put_cyc.push_back(cyc);
            put_beats++;
            if (put_beats == N) begin
              put_beats = 0;
              d_q.push_back('{3'd0, 128'd0, 1'b0});
            end
          end
        end
      end
    end
  end

  int unsigned rsp_cyc;

  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [LW-1:0] line,
                         input logic chk_data, input logic [LW-1:0] exp_data,
                         input logic exp_err, input int hold);
    exp_t e;
    int   budget;
    @(negedge clk);
    check("req_ready_idle", LW'(req_ready), LW'(1));
    a_log.delete();
    put_cyc.delete();
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_data = line;
    sb.push_back('{exp_data, chk_data, exp_err});
    @(negedge clk);
    req_valid = 1'b0;
    check("a_valid_t1", LW'(a_valid), LW'(1));
    budget = 0;
    while (!rsp_valid && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!rsp_valid) begin
      check("rsp_timeout", LW'(rsp_valid), LW'(1));
      void'(sb.pop_front());
      return;
    end
    rsp_cyc = cyc;
    e = sb.pop_front();
    if (e.chk_data) check("rsp_data", rsp_data, e.data);
    check("rsp_err", LW'(rsp_err), LW'(e.err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", LW'(rsp_valid), LW'(1));
      check("hold_ready", LW'(req_ready), LW'(0));
      if (e.chk_data) check("hold_data", rsp_data, e.data);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("req_ready_after", LW'(req_ready), LW'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, LW'({req_ready, a_valid, d_ready, rsp_valid, rsp_err}), LW'(5'b10000));
    check({tag, "_afields"}, LW'({a_opcode, a_param, a_size, a_source, a_address, a_mask, a_corrupt}), '0);
    check({tag, "_adata"}, LW'(a_data), '0);
    check({tag, "_rsp_data"}, rsp_data, '0);
  endtask

  logic [127:0]  pre [N];
  logic [LW-1:0] rd_line, wr_line;
  int            d_before;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_data = '0; rsp_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      pre[k] = {$urandom, $urandom, $urandom, 24'h0, 8'(k)};
      mem[28'h8000004 + 28'(k)] = pre[k];
      rd_line[128*k +: 128] = pre[k];
      wr_line[128*k +: 128] = {64'h0123_4567_89AB_CDEF, 56'h0, 8'(8'hA0 + k)};
    end
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Line read, unaligned offset ignored
    run_txn(1'b0, 32'h8000_0047, '0, 1'b1, rd_line, 1'b0, 0);
    check("rd_a_count", LW'(a_log.size()), LW'(1));
    check("rd_a_beat", LW'({a_log[0].op, a_log[0].size, a_log[0].addr, a_log[0].mask}),
          LW'({3'd4, 8'd6, 32'h8000_0040, 16'hFFFF}));
    check("rd_rsp_timing", LW'(rsp_cyc), LW'(last_d_cyc + 1));

    // Line write with a_ready high: back-to-back beats
    run_txn(1'b1, 32'h8000_0100, wr_line, 1'b0, '0, 1'b0, 0);
    check("wr_a_count", LW'(a_log.size()), LW'(N));
    for (int k = 0; k < a_log.size() && k < N; k++) begin
      check("wr_beat", LW'({a_log[k].op, a_log[k].addr, a_log[k].mask, a_log[k].data}),
            LW'({3'd0, 32'h8000_0100 + 32'(16 * k), 16'hFFFF, wr_line[128*k +: 128]}));
      check("wr_beat_cycle", LW'(put_cyc[k]), LW'(put_cyc[0] + k));
    end
    run_txn(1'b0, 32'h8000_0100, '0, 1'b1, wr_line, 1'b0, 0);

    // Write with a_ready toggling randomly
    for (int k = 0; k < N; k++) wr_line[128*k +: 128] = {$urandom, $urandom, $urandom, $urandom};
    rand_ready = 1'b1;
    run_txn(1'b1, 32'h8000_0180, wr_line, 1'b0, '0, 1'b0, 0);
    rand_ready = 1'b0;
    check("rnd_a_count", LW'(a_log.size()), LW'(N));
    for (int k = 0; k < a_log.size() && k < N; k++)
      check("rnd_addr", LW'(a_log[k].addr), LW'(32'h8000_0180 + 32'(16 * k)));
    run_txn(1'b0, 32'h8000_0180, '0, 1'b1, wr_line, 1'b0, 0);

    // Denied D beat; every beat still consumed, then err cleared next time
    deny_beat = 2;
    d_before  = d_cnt;
    run_txn(1'b0, 32'h8000_0040, '0, 1'b0, '0, 1'b1, 0);
    deny_beat = -1;
    check("deny_beats", LW'(d_cnt - d_before), LW'(N));
    check("deny_drained", LW'(d_q.size()), LW'(0));
    run_txn(1'b0, 32'h8000_0040, '0, 1'b1, rd_line, 1'b0, 0);

    // Response back-pressure
    run_txn(1'b0, 32'h8000_0040, '0, 1'b1, rd_line, 1'b0, 5);

    // Reset after two of four PUT beats
    @(negedge clk);
    put_cyc.delete();
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h8000_0200; req_data = wr_line;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    check("midrst_beats", LW'(put_cyc.size()), LW'(2));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_txn(1'b0, 32'h8000_0040, '0, 1'b1, rd_line, 1'b0, 0);

    check("sb_empty", LW'(sb.size()), LW'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tl_line_master.md
# tl_line_master

TileLink-UL initiator that moves one whole cache line between a core-side line port and a 128-bit TileLink slave (for example the testbench memory model). A line read is issued as a single Get and gathers N AccessAckData beats. A line write is issued as N PutFullData beats and waits for one AccessAck. It sits between the L1 refill/writeback logic and the system TileLink port, and is the A-channel driver / D-channel sink for slaves of that shape.

## Interface
Parameters:
- LINE_BYTES, 64: line size in bytes; a power of two, at least 16. Beats per line N = LINE_BYTES/16.
- SOURCE_ID, 0: constant a_source value.

Ports:
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-high
- req_valid  in  1  line request offered
- req_ready  out  1  block idle, request accepted
- req_wr  in  1  1 = write line, 0 = read line
- req_addr  in  32  line address; low log2(LINE_BYTES) bits are ignored and forced to 0
- req_data  in  8*LINE_BYTES  write line; beat k = bits [128k +: 128]
- rsp_valid  out  1  transaction complete
- rsp_ready  in  1  response consumed
- rsp_data  out  8*LINE_BYTES  read line; undefined for writes
- rsp_err  out  1  denied, corrupt or bad opcode seen on any D beat
- a_opcode  out  3, a_param  out  3, a_size  out  8, a_source  out  3, a_address  out  32, a_mask  out  16, a_data  out  128, a_corrupt  out  1, a_valid  out  1, a_ready  in  1: TileLink A channel
- d_opcode  in  3, d_param  in  2, d_size  in  8, d_source  in  3, d_sink  in  3, d_denied  in  1, d_data  in  128, d_corrupt  in  1, d_valid  in  1, d_ready  out  1: TileLink D channel

## Operation
- States: IDLE, PUT, GET, WAIT_ACK, RECV, RESP.
- IDLE
  - req_ready = 1.
  - On req_valid: latch the aligned address, the line and the direction.
  - Clear beat counter `cnt` and `err`.
  - Go to PUT if req_wr, otherwise GET.
- PUT
  - a_valid = 1, a_opcode = 0 (PutFullData), a_data = beat `cnt`, a_mask = 16'hFFFF.
  - a_address = line address + 16·cnt.
  - On each A handshake, `cnt` increments.
  - A handshake with cnt = N-1 goes to WAIT_ACK.
- GET
  - a_valid = 1, a_opcode = 4 (Get), a_address = line address, a_mask = 16'hFFFF.
  - A handshake goes to RECV with `cnt` = 0.
- Fields common to every A beat:
  - a_size = log2(LINE_BYTES).
  - a_param = 0, a_corrupt = 0, a_source = SOURCE_ID.
- RECV
  - d_ready = 1.
  - Each D handshake writes d_data into buffer beat `cnt` and increments `cnt`.
  - `err` |= d_denied | d_corrupt | (d_opcode != 1).
  - The handshake at cnt = N-1 goes to RESP.
- WAIT_ACK
  - d_ready = 1.
  - One D handshake goes to RESP.
  - `err` |= d_denied | d_corrupt | (d_opcode != 0).
- RESP
  - rsp_valid = 1; rsp_data and rsp_err are held stable.
  - rsp_ready goes to IDLE.
- Outside RECV and WAIT_ACK, d_ready = 0; D traffic is not consumed.
- d_param, d_size, d_source and d_sink are ignored.
- `cnt` width is log2(N)+1; no wrap within a line.
- Reset mid-operation: state returns to IDLE and partial buffer contents are discarded. Any slave beats still in flight are the slave's concern; the block must not hang.

## Timing
Reset values of outputs:
- req_ready = 1.
- a_valid = 0, d_ready = 0, rsp_valid = 0, rsp_err = 0.
- All A fields 0; rsp_data 0.

Cycle-level behaviour:
- All control outputs are decoded from registered state; no combinational path from a_ready or d_valid to a_valid.
- The request is accepted at cycle t. The first A beat is valid at t+1.
- a_valid is held and A fields are stable until a_ready.
- With a_ready tied to 1, a write issues its N beats on cycles t+1 … t+N, back to back.
- A D beat is accepted in the same cycle d_valid is seen, when d_ready = 1.
- rsp_valid rises the cycle after the final D handshake and stays high until rsp_ready.
- req_ready goes high the cycle after the rsp handshake. There is no overlap between transactions.

## Structure
- Shared package tl_pkg holds:
  - opcode constants: PUT_FULL = 0, GET = 4, ACCESS_ACK = 0, ACCESS_ACK_DATA = 1;
  - the data-beat width of 128;
  - the state enum.
- Single module, no sub-module. The line buffer is a flat register indexed by `cnt`.

## Test plan
- Read, memory preloaded, line at 0x80000040, LINE_BYTES = 64, a_ready = 1, slave returns 4 beats back to back:
  - one A beat: opcode 4, size 6, address 0x80000040;
  - rsp_data equals the 4 preloaded beats in order, rsp_err = 0;
  - rsp_valid arrives one cycle after the 4th D beat.
- Write, line of beats 0x…A0 to 0x…A3 at 0x80000100:
  - A beats on 4 consecutive cycles with addresses 0x…100, 110, 120, 130 and mask FFFF;
  - a single AccessAck leads to rsp_valid with rsp_err = 0;
  - a read-back returns the same data.
- a_ready toggled 1/0 randomly during a write: a_data and a_address are held stable while stalled, and no beat is skipped or duplicated.
- D beat 2 of a read carries d_denied = 1: all 4 beats are still consumed and rsp_err = 1. The next transaction starts with err cleared.
- rsp_ready held low 5 cycles: rsp_valid and rsp_data are stable, and req_ready = 0 throughout.
- rst asserted after 2 of 4 PUT beats:
  - all outputs return to reset values immediately;
  - after release, a new read completes correctly.
